// File: rtl/uart_pkg.sv
// UART shared package: transmit FSM states, stop-bit modes, frame size and
// IRQ_EVENT bit positions used by the UART transmit and receive paths.
package uart_pkg;

    // Data bits per UART frame; matches the downstream FIFO word width.
    localparam int UART_DATA_BITS = 8;

    // Bit positions of the transmit events inside IRQ_EVENT.
    localparam int IRQ_TX_STARTED = 0;
    localparam int IRQ_TX_DONE    = 1;

    // Stop-period length selection from CTRL.stop_bit_mode.
    typedef enum logic [1:0] {
        HALF_PERIOD          = 2'd0,
        FULL_PERIOD          = 2'd1,
        ONE_AND_HALF_PERIODS = 2'd2,
        TWO_PERIODS          = 2'd3
    } stop_bit_mode_t;

    // Transmit sequencer states.
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_sequencer_if.sv
// Downstream FIFO read port as seen by the UART transmit sequencer.
// master = FIFO side (provides show-ahead head word and empty flag),
// slave  = sequencer side (issues the one-cycle pop strobe).
interface uart_tx_sequencer_if;
    import uart_pkg::*;

    logic                      dfifo_empty;
    logic [UART_DATA_BITS-1:0] dfifo_data;
    logic                      dfifo_rd;

    modport master (
        output dfifo_empty,
        output dfifo_data,
        input  dfifo_rd
    );

    modport slave (
        input  dfifo_empty,
        input  dfifo_data,
        output dfifo_rd
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter for UART bit timing. A load writes the terminal
// count (period - 1); the counter then walks down and holds at zero, where
// tick_o is high. Also intended for reuse by the receiver.
module uart_bit_timer #(
    parameter int WIDTH = 33
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic             tick_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: load has priority, otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: pops bytes from the downstream FIFO and drives
// start bit, data bits (LSB- or MSB-first), optional even parity and the
// stop period on tx_o. Framing options are captured when a frame launches.
// Optional feature macro: UART_TX_CTS_SYNC_EN (2-flop synchronizer on cts_n_i).
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [CNT_WIDTH-1:0] bit_length_i,
    input  logic [1:0]           stop_bit_mode_i,
    input  logic [1:0]           stop_bit_value_i,
    input  logic                 msb_first_i,
    input  logic                 send_parity_i,
    input  logic                 hw_flow_ctrl_en_i,
    input  logic                 cts_n_i,
    uart_tx_sequencer_if.slave   dfifo,
    output logic                 tx_o,
    output logic                 tx_busy_o,
    output logic                 irq_tx_started_o,
    output logic                 irq_tx_done_o
);

    // One extra bit so that 2L and L + L/2 never wrap.
    localparam int TW    = CNT_WIDTH + 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [TW-1:0]    ONE      = TW'(1);

    uart_tx_state_t state_q, state_d;

    logic [DATA_BITS-1:0] shift_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [TW-1:0]        len_q;
    logic [TW-1:0]        stop_len_q;
    logic                 msb_first_q;
    logic                 send_parity_q;
    logic                 parity_bit_q;
    logic                 stop_level_q;
    logic                 started_q;

    logic [TW-1:0] len_in;
    logic [TW-1:0] half_raw;
    logic [TW-1:0] half_in;
    logic [TW-1:0] stop_in;
    logic          cts_n_eff;
    logic          ready;
    logic          launch;
    logic          shift_en;
    logic          done;
    logic          rd;
    logic          tmr_load;
    logic [TW-1:0] tmr_value;
    logic          tmr_tick;
    logic          data_bit;
    logic          unused_stop_value;

    // Only bit 0 of the stop value selects the line level; bit 1 is reserved.
    assign unused_stop_value = stop_bit_value_i[1];

    assign len_in   = (bit_length_i == '0) ? ONE : {1'b0, bit_length_i};
    assign half_raw = len_in >> 1;
    assign half_in  = (half_raw == '0) ? ONE : half_raw;

    // Stop-period length for the frame about to launch.
    always_comb begin
        stop_in = len_in;
        case (stop_bit_mode_t'(stop_bit_mode_i))
            HALF_PERIOD:          stop_in = half_in;
            FULL_PERIOD:          stop_in = len_in;
            ONE_AND_HALF_PERIODS: stop_in = len_in + half_raw;
            TWO_PERIODS:          stop_in = len_in << 1;
            default:              stop_in = len_in;
        endcase
    end

`ifdef UART_TX_CTS_SYNC_EN
    logic [1:0] cts_sync_q;

    // Two-flop synchronizer; idles at "not clear to send".
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cts_sync_q <= 2'b11;
        end else begin
            cts_sync_q <= {cts_sync_q[0], cts_n_i};
        end
    end

    assign cts_n_eff = cts_sync_q[1];
`else
    assign cts_n_eff = cts_n_i;
`endif

    // Reset is folded in so no pop can fire while the block is held in reset.
    assign ready = !dfifo.dfifo_empty && (!hw_flow_ctrl_en_i || !cts_n_eff) && !rst_i;

    uart_bit_timer #(
        .WIDTH(TW)
    ) u_bit_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (tmr_load),
        .load_value_i(tmr_value),
        .tick_o      (tmr_tick)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= TX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, pop strobe, timer reload and frame-done decode.
    always_comb begin
        state_d   = state_q;
        rd        = 1'b0;
        launch    = 1'b0;
        shift_en  = 1'b0;
        done      = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state_q)
            TX_IDLE: begin
                if (ready) begin
                    rd        = 1'b1;
                    launch    = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_value = len_in - ONE;
                    state_d   = TX_START;
                end
            end
            TX_START: begin
                if (tmr_tick) begin
                    tmr_load  = 1'b1;
                    tmr_value = len_q - ONE;
                    state_d   = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tmr_tick) begin
                    tmr_load = 1'b1;
                    if (bit_idx_q != LAST_IDX) begin
                        shift_en  = 1'b1;
                        tmr_value = len_q - ONE;
                    end else if (send_parity_q) begin
                        tmr_value = len_q - ONE;
                        state_d   = TX_PARITY;
                    end else begin
                        tmr_value = stop_len_q - ONE;
                        state_d   = TX_STOP;
                    end
                end
            end
            TX_PARITY: begin
                if (tmr_tick) begin
                    tmr_load  = 1'b1;
                    tmr_value = stop_len_q - ONE;
                    state_d   = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tmr_tick) begin
                    done = 1'b1;
                    if (ready) begin
                        rd        = 1'b1;
                        launch    = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_value = len_in - ONE;
                        state_d   = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Frame datapath: capture byte and framing options at launch, then shift.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q       <= '0;
            bit_idx_q     <= '0;
            len_q         <= '0;
            stop_len_q    <= '0;
            msb_first_q   <= 1'b0;
            send_parity_q <= 1'b0;
            parity_bit_q  <= 1'b0;
            stop_level_q  <= 1'b1;
            started_q     <= 1'b0;
        end else begin
            started_q <= launch;
            if (launch) begin
                shift_q       <= dfifo.dfifo_data;
                bit_idx_q     <= '0;
                len_q         <= len_in;
                stop_len_q    <= stop_in;
                msb_first_q   <= msb_first_i;
                send_parity_q <= send_parity_i;
                parity_bit_q  <= ^dfifo.dfifo_data;
                stop_level_q  <= stop_bit_value_i[0];
            end else if (shift_en) begin
                shift_q   <= msb_first_q ? (shift_q << 1) : (shift_q >> 1);
                bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
        end
    end

    assign data_bit = msb_first_q ? shift_q[DATA_BITS-1] : shift_q[0];

    // Serial line level for the current state; idle and reset hold it high.
    always_comb begin
        tx_o = 1'b1;
        case (state_q)
            TX_IDLE:   tx_o = 1'b1;
            TX_START:  tx_o = 1'b0;
            TX_DATA:   tx_o = data_bit;
            TX_PARITY: tx_o = parity_bit_q;
            TX_STOP:   tx_o = stop_level_q;
            default:   tx_o = 1'b1;
        endcase
    end

    assign dfifo.dfifo_rd   = rd;
    assign tx_busy_o        = (state_q != TX_IDLE);
    assign irq_tx_started_o = started_q;
    assign irq_tx_done_o    = done;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed self-checking bench for uart_tx_sequencer (default build, CTS used
// directly). A queue stands in for the downstream FIFO; each frame is checked
// segment by segment against hand-computed bit orders and pulse positions.
module tb_uart_tx_sequencer;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bit_length;
    logic [1:0]  stop_mode;
    logic [1:0]  stop_value;
    logic        msb_first;
    logic        send_parity;
    logic        hw_flow;
    logic        cts_n;
    logic        tx;
    logic        busy;
    logic        started;
    logic        done;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] fifoQ[$];
    int         frameCyc;
    int         startedCyc;
    int         startedCnt;
    int         doneCyc;
    int         doneCnt;
    int         busyLow;
    int         popCount     = 0;
    int         rdWhileEmpty = 0;
    int         tmpCount;
    int         popBase;
    logic       lastRd;

    uart_tx_sequencer_if sif ();

    uart_tx_sequencer #(
        .CNT_WIDTH(32),
        .DATA_BITS(8)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .bit_length_i     (bit_length),
        .stop_bit_mode_i  (stop_mode),
        .stop_bit_value_i (stop_value),
        .msb_first_i      (msb_first),
        .send_parity_i    (send_parity),
        .hw_flow_ctrl_en_i(hw_flow),
        .cts_n_i          (cts_n),
        .dfifo            (sif),
        .tx_o             (tx),
        .tx_busy_o        (busy),
        .irq_tx_started_o (started),
        .irq_tx_done_o    (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic updateFifo();
        sif.dfifo_empty = (fifoQ.size() == 0);
        sif.dfifo_data  = (fifoQ.size() != 0) ? fifoQ[0] : 8'h00;
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        fifoQ.push_back(d);
        updateFifo();
        #1;
    endtask

    task automatic setConfig(input int len, input logic [1:0] mode, input logic [1:0] sval,
                             input logic msb, input logic par);
        bit_length  = 32'(len);
        stop_mode   = mode;
        stop_value  = sval;
        msb_first   = msb;
        send_parity = par;
        #1;
    endtask

    // Advance to the next sampling point (negedge + 1), popping on a strobe.
    task automatic stepCycle();
        logic rdNow;
        rdNow = sif.dfifo_rd;
        if (rdNow && sif.dfifo_empty) rdWhileEmpty++;
        @(negedge clk);
        if (rdNow && fifoQ.size() != 0) begin
            void'(fifoQ.pop_front());
            popCount++;
        end
        updateFifo();
        #1;
        frameCyc++;
    endtask

    task automatic sampleCycle();
        if (started) begin startedCnt++; startedCyc = frameCyc; end
        if (done) begin doneCnt++; doneCyc = frameCyc; end
        if (!busy) busyLow++;
        lastRd = sif.dfifo_rd;
    endtask

    task automatic checkSegment(input string tag, input logic v, input int n);
        int good;
        good = 0;
        for (int i = 0; i < n; i++) begin
            sampleCycle();
            if (tx === v) good++;
            stepCycle();
        end
        checkOutput(tag, 64'(good), 64'(n));
    endtask

    // Called on the first START cycle; bits[7] is the first data bit on the line.
    task automatic sendFrame(input string tag, input int len, input logic [7:0] bits,
                             input logic par, input logic parVal, input logic stopLvl,
                             input int stopLen, input int expDone, input logic expRdEnd);
        frameCyc   = 1;
        startedCnt = 0;
        startedCyc = 0;
        doneCnt    = 0;
        doneCyc    = 0;
        busyLow    = 0;
        checkSegment({tag, ".start"}, 1'b0, len);
        for (int b = 7; b >= 0; b--) begin
            checkSegment($sformatf("%s.d%0d", tag, 7 - b), bits[b], len);
        end
        if (par) checkSegment({tag, ".parity"}, parVal, len);
        checkSegment({tag, ".stop"}, stopLvl, stopLen);
        checkOutput({tag, ".started_cyc"}, 64'(startedCyc), 64'd1);
        checkOutput({tag, ".started_cnt"}, 64'(startedCnt), 64'd1);
        checkOutput({tag, ".done_cnt"}, 64'(doneCnt), 64'd1);
        checkOutput({tag, ".done_cyc"}, 64'(doneCyc), 64'(expDone));
        checkOutput({tag, ".busy_low"}, 64'(busyLow), 64'd0);
        checkOutput({tag, ".rd_at_end"}, 64'(lastRd), 64'(expRdEnd));
    endtask

    task automatic launchFrame(input string tag, input logic [7:0] d);
        applyStimulus(d);
        checkOutput({tag, ".rd_launch"}, 64'(sif.dfifo_rd), 64'd1);
        stepCycle();
    endtask

    initial begin
        rst = 1'b1;
        hw_flow = 1'b0;
        cts_n = 1'b1;
        setConfig(4, FULL_PERIOD, 2'b01, 1'b0, 1'b0);
        updateFifo();
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset.tx", 64'(tx), 64'd1);
        checkOutput("reset.busy", 64'(busy), 64'd0);
        checkOutput("reset.started", 64'(started), 64'd0);
        checkOutput("reset.done", 64'(done), 64'd0);
        checkOutput("reset.rd", 64'(sif.dfifo_rd), 64'd0);
        rst = 1'b0;
        #1;
        stepCycle();
        checkOutput("idle.tx", 64'(tx), 64'd1);

        $display("[TB] L=4 LSB-first 0xA5, no parity");
        launchFrame("f1", 8'hA5);
        sendFrame("f1", 4, 8'hA5, 1'b0, 1'b0, 1'b1, 4, 40, 1'b0);
        checkOutput("f1.idle_tx", 64'(tx), 64'd1);
        checkOutput("f1.idle_busy", 64'(busy), 64'd0);

        $display("[TB] L=4 MSB-first with parity");
        setConfig(4, FULL_PERIOD, 2'b01, 1'b1, 1'b1);
        launchFrame("f2", 8'hA5);
        sendFrame("f2", 4, 8'hA5, 1'b1, 1'b0, 1'b1, 4, 44, 1'b0);
        launchFrame("f3", 8'h0B);
        sendFrame("f3", 4, 8'h0B, 1'b1, 1'b1, 1'b1, 4, 44, 1'b0);

        $display("[TB] L=5 stop-mode sweep");
        setConfig(5, HALF_PERIOD, 2'b01, 1'b0, 1'b0);
        launchFrame("half", 8'h0B);
        sendFrame("half", 5, 8'hD0, 1'b0, 1'b0, 1'b1, 2, 47, 1'b0);
        setConfig(5, FULL_PERIOD, 2'b01, 1'b0, 1'b0);
        launchFrame("full", 8'h0B);
        sendFrame("full", 5, 8'hD0, 1'b0, 1'b0, 1'b1, 5, 50, 1'b0);
        setConfig(5, ONE_AND_HALF_PERIODS, 2'b01, 1'b0, 1'b0);
        launchFrame("onehalf", 8'h0B);
        sendFrame("onehalf", 5, 8'hD0, 1'b0, 1'b0, 1'b1, 7, 52, 1'b0);
        setConfig(5, TWO_PERIODS, 2'b01, 1'b0, 1'b0);
        launchFrame("two", 8'h0B);
        sendFrame("two", 5, 8'hD0, 1'b0, 1'b0, 1'b1, 10, 55, 1'b0);
        setConfig(5, FULL_PERIOD, 2'b10, 1'b0, 1'b0);
        launchFrame("stoplow", 8'h0B);
        sendFrame("stoplow", 5, 8'hD0, 1'b0, 1'b0, 1'b0, 5, 50, 1'b0);
        checkOutput("stoplow.idle_tx", 64'(tx), 64'd1);

        $display("[TB] bit_length 0 behaves as 1");
        setConfig(0, FULL_PERIOD, 2'b01, 1'b0, 1'b0);
        launchFrame("l0", 8'h0B);
        sendFrame("l0", 1, 8'hD0, 1'b0, 1'b0, 1'b1, 1, 10, 1'b0);

        $display("[TB] three queued bytes back to back");
        setConfig(2, FULL_PERIOD, 2'b01, 1'b0, 1'b0);
        popBase = popCount;
        fifoQ.push_back(8'h12);
        fifoQ.push_back(8'hC3);
        launchFrame("b2b0", 8'h01);
        sendFrame("b2b0", 2, 8'h48, 1'b0, 1'b0, 1'b1, 2, 20, 1'b1);
        sendFrame("b2b1", 2, 8'hC3, 1'b0, 1'b0, 1'b1, 2, 20, 1'b1);
        sendFrame("b2b2", 2, 8'h80, 1'b0, 1'b0, 1'b1, 2, 20, 1'b0);
        checkOutput("b2b.pops", 64'(popCount - popBase), 64'd3);

        $display("[TB] CTS flow control");
        hw_flow = 1'b1;
        cts_n = 1'b1;
        fifoQ.push_back(8'h0B);
        applyStimulus(8'hA5);
        tmpCount = 0;
        for (int i = 0; i < 3; i++) begin
            if (sif.dfifo_rd === 1'b0 && tx === 1'b1 && busy === 1'b0) tmpCount++;
            stepCycle();
        end
        checkOutput("cts.blocked", 64'(tmpCount), 64'd3);
        cts_n = 1'b0;
        #1;
        checkOutput("cts.rd_launch", 64'(sif.dfifo_rd), 64'd1);
        stepCycle();
        cts_n = 1'b1;
        setConfig(9, TWO_PERIODS, 2'b01, 1'b1, 1'b1);
        sendFrame("cts", 2, 8'hD0, 1'b0, 1'b0, 1'b1, 2, 20, 1'b0);
        tmpCount = 0;
        for (int i = 0; i < 2; i++) begin
            if (sif.dfifo_rd === 1'b0 && tx === 1'b1) tmpCount++;
            stepCycle();
        end
        checkOutput("cts.held", 64'(tmpCount), 64'd2);
        hw_flow = 1'b0;
        #1;
        checkOutput("cts.rd_release", 64'(sif.dfifo_rd), 64'd1);
        stepCycle();
        sendFrame("newcfg", 9, 8'hA5, 1'b1, 1'b0, 1'b1, 18, 108, 1'b0);

        $display("[TB] reset during DATA");
        setConfig(3, FULL_PERIOD, 2'b01, 1'b0, 1'b0);
        popBase = popCount;
        fifoQ.push_back(8'h0B);
        applyStimulus(8'h12);
        checkOutput("rstmid.rd_launch", 64'(sif.dfifo_rd), 64'd1);
        for (int i = 0; i < 6; i++) stepCycle();
        checkOutput("rstmid.busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("rstmid.tx", 64'(tx), 64'd1);
        checkOutput("rstmid.busy", 64'(busy), 64'd0);
        checkOutput("rstmid.done", 64'(done), 64'd0);
        checkOutput("rstmid.rd", 64'(sif.dfifo_rd), 64'd0);
        stepCycle();
        checkOutput("rstmid.held_tx", 64'(tx), 64'd1);
        rst = 1'b0;
        #1;
        checkOutput("rstmid.rd_after", 64'(sif.dfifo_rd), 64'd1);
        stepCycle();
        sendFrame("rstnext", 3, 8'h48, 1'b0, 1'b0, 1'b1, 3, 30, 1'b0);
        checkOutput("rstmid.pops", 64'(popCount - popBase), 64'd2);

        checkOutput("rd_while_empty", 64'(rdWhileEmpty), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
